ss_scan_encoder: RTL
====================

SS_SCAN_ENCODER -- requirements
Module: ss_scan_encoder

Interface
REQ-001 The block SHALL be clocked by a single clock and reset by a synchronous, active-high reset.
REQ-002 Parameter: STABLE_CNT, default 4, number of consecutive repeat samples required before a digit is captured (legal range 1..255).
REQ-003 Port: clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: segment  input  8  active-low segment bus; bit7 = dp, bits 6:0 = g,f,e,d,c,b,a.
REQ-006 Port: digit_sel  input  4  active-low anode select; bit n low selects digit n.
REQ-007 Port: value  output  16  decoded hex word; digit n in bits 4n+3:4n.
REQ-008 Port: valid  output  1  high once at least one complete frame has been captured.
REQ-009 Port: digit_err  output  4  bit n high if digit n's pattern matched no table code in the last frame.
REQ-010 Port: frame_done  output  1  single-cycle pulse on frame completion.
REQ-011 Port: dp  output  4  decimal-point state per digit, 1 = lit (present only under SS_ENC_DP_EN).

Function
REQ-012 The block SHALL sample segment and digit_sel into registers every cycle.
REQ-013 A sample SHALL be "legal" only when digit_sel has exactly one bit low.
REQ-014 The stability counter SHALL increment (saturating at STABLE_CNT) when the current sample is legal and equal, in all 12 bits, to the previous sample; otherwise it SHALL clear to 0.
REQ-015 A capture SHALL occur on the edge where the counter reaches STABLE_CNT, i.e. after STABLE_CNT+1 identical legal samples; at most one capture per dwell.
REQ-016 Capture decode SHALL use segment[6:0] only: 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7, 0x00->8, 0x10->9, 0x08->A, 0x03->B, 0x46->C, 0x21->D, 0x06->E, 0x0E->F.
REQ-017 An unmatched pattern SHALL capture nibble 0 and set that digit's pending error bit; a match SHALL clear it.
REQ-018 Captures SHALL write into a shadow word and set the digit's bit in a 4-bit captured mask; re-capture of an already-captured digit SHALL overwrite its nibble (latest wins) without affecting the mask.
REQ-019 On the edge at which the mask becomes 4'b1111, value, digit_err (and dp) SHALL load from the shadow atomically, valid SHALL set, the mask SHALL clear, and frame_done SHALL be high for exactly the following cycle.
REQ-020 Outputs SHALL hold between frame completions; partial frames SHALL never alter value.
REQ-021 digit_sel = 4'hF (blank) or multi-hot SHALL clear the counter and cause no capture.
REQ-022 A change of segment or digit_sel mid-dwell SHALL restart the count for the new pair.

Reset
REQ-023 On rst: value = 16'h0000, valid = 0, digit_err = 4'h0, frame_done = 0, dp = 4'h0, captured mask, shadow, sample registers and counter cleared.
REQ-024 Reset mid-frame SHALL discard all partial captures; the next frame starts from an empty mask.

Configuration
REQ-025 Macro SS_ENC_DP_EN: when defined, the dp port exists and dp[n] = ~segment[7] captured with digit n, loaded at frame completion.
REQ-026 When SS_ENC_DP_EN is undefined, the dp port and its registers SHALL be absent and segment[7] SHALL be ignored for stability comparison and decode.

Verification
REQ-027 STABLE_CNT=4; present digits 0..3 as 0x30,0x24,0x79,0x40 (dp off), 5 cycles each -> frame_done one cycle after the 4th capture, value = 16'h0123, digit_err = 0, valid = 1.
REQ-028 Hold digit 0 for only 4 identical cycles, then move on -> no capture for digit 0; no frame_done until digit 0 is held 5 cycles.
REQ-029 Digit 2 pattern 0x7F -> value[11:8] = 0, digit_err = 4'b0100 after the frame.
REQ-030 digit_sel = 4'b1100 or 4'hF for 20 cycles -> no capture, no frame_done, outputs unchanged.
REQ-031 Capture digits 0,1,2, assert rst one cycle, then full frame of 'F' on all digits -> value = 16'hFFFF, exactly one frame_done.
REQ-032 SS_ENC_DP_EN defined, digit 1 with segment = 0x79 (dp lit) -> dp = 4'b0010; undefined, same stimulus -> value unaffected by segment[7].

Source files
------------

// File: rtl/ss_scan_encoder.sv
`default_nettype none
// ============================================================================
// Module      : ss_scan_encoder
// Description : Watches a multiplexed, active-low 7-segment display bus and
//               recovers the 4-digit hex word shown on it. A digit is taken
//               once its segment/anode pair has stayed put long enough. The
//               outputs update only when all four digits have been taken.
//               Optional macro SS_ENC_DP_EN adds per-digit decimal-point
//               recovery on the dp port.
// Revision    : 1.0 - initial release
// ============================================================================
module ss_scan_encoder #(
    parameter int STABLE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  segment,
    input  logic [3:0]  digit_sel,
    output logic [15:0] value,
    output logic        valid,
    output logic [3:0]  digit_err,
`ifdef SS_ENC_DP_EN
    output logic [3:0]  dp,
`endif
    output logic        frame_done
);

    // The decimal point takes part in sampling only when it is recovered.
`ifdef SS_ENC_DP_EN
    localparam int c_SEG_W = 8;
`else
    localparam int c_SEG_W = 7;
`endif
    localparam logic [7:0] c_STABLE = 8'(STABLE_CNT);

    logic [c_SEG_W-1:0] w_seg_in;
    logic [c_SEG_W-1:0] r_cur_seg;
    logic [c_SEG_W-1:0] r_prev_seg;
    logic [3:0]         r_cur_sel;
    logic [3:0]         r_prev_sel;
    logic [7:0]         r_cnt;
    logic [3:0]         r_mask;
    logic [15:0]        r_shadow;
    logic [3:0]         r_shadow_err;
    logic [15:0]        r_value;
    logic               r_valid;
    logic [3:0]         r_err;
    logic               r_frame_done;

    logic               w_legal;
    logic [1:0]         w_idx;
    logic               w_same;
    logic               w_capture;
    logic [3:0]         w_nibble;
    logic               w_match;
    logic [3:0]         w_mask_next;
    logic [15:0]        w_shadow_next;
    logic [3:0]         w_err_next;
    logic               w_frame;

`ifdef SS_ENC_DP_EN
    logic [3:0]         r_shadow_dp;
    logic [3:0]         w_dp_next;
    logic [3:0]         r_dp;
`else
    logic               w_unused_dp_bit;
    assign w_unused_dp_bit = segment[7];
`endif

    assign w_seg_in = segment[c_SEG_W-1:0];

    // Register the display bus every cycle, keeping one sample of history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_seg  <= '0;
            r_prev_seg <= '0;
            r_cur_sel  <= 4'h0;
            r_prev_sel <= 4'h0;
        end else begin
            r_cur_seg  <= w_seg_in;
            r_prev_seg <= r_cur_seg;
            r_cur_sel  <= digit_sel;
            r_prev_sel <= r_cur_sel;
        end
    end

    // Exactly one anode low is a legal sample; map it to a digit index.
    always_comb begin
        w_legal = 1'b1;
        w_idx   = 2'd0;
        case (r_cur_sel)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_same    = (r_cur_seg == r_prev_seg) && (r_cur_sel == r_prev_sel);
    // Fires only on the transition into the saturated count, so once per dwell.
    assign w_capture = w_legal && w_same && (r_cnt == c_STABLE - 8'd1);

    // Segment pattern to hex nibble; anything off-table decodes to 0 and flags.
    always_comb begin
        w_nibble = 4'h0;
        w_match  = 1'b1;
        case (r_cur_seg[6:0])
            7'h40: w_nibble = 4'h0;
            7'h79: w_nibble = 4'h1;
            7'h24: w_nibble = 4'h2;
            7'h30: w_nibble = 4'h3;
            7'h19: w_nibble = 4'h4;
            7'h12: w_nibble = 4'h5;
            7'h02: w_nibble = 4'h6;
            7'h78: w_nibble = 4'h7;
            7'h00: w_nibble = 4'h8;
            7'h10: w_nibble = 4'h9;
            7'h08: w_nibble = 4'hA;
            7'h03: w_nibble = 4'hB;
            7'h46: w_nibble = 4'hC;
            7'h21: w_nibble = 4'hD;
            7'h06: w_nibble = 4'hE;
            7'h0E: w_nibble = 4'hF;
            default: w_match = 1'b0;
        endcase
    end

    // Next shadow contents with the current capture merged in (latest wins).
    always_comb begin
        w_shadow_next = r_shadow;
        w_err_next    = r_shadow_err;
        w_mask_next   = r_mask;
`ifdef SS_ENC_DP_EN
        w_dp_next     = r_shadow_dp;
`endif
        if (w_capture) begin
            w_shadow_next[{w_idx, 2'b00} +: 4] = w_nibble;
            w_err_next[w_idx]                  = ~w_match;
            w_mask_next[w_idx]                 = 1'b1;
`ifdef SS_ENC_DP_EN
            w_dp_next[w_idx]                   = ~r_cur_seg[7];
`endif
        end
    end

    assign w_frame = w_capture && (w_mask_next == 4'hF);

    // Saturating stability counter; any illegal or changed sample restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (w_legal && w_same) begin
            if (r_cnt != c_STABLE) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end else begin
            r_cnt <= 8'd0;
        end
    end

    // Shadow capture, and atomic output load when the fourth digit lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow     <= 16'h0000;
            r_shadow_err <= 4'h0;
            r_mask       <= 4'h0;
            r_value      <= 16'h0000;
            r_valid      <= 1'b0;
            r_err        <= 4'h0;
            r_frame_done <= 1'b0;
`ifdef SS_ENC_DP_EN
            r_shadow_dp  <= 4'h0;
            r_dp         <= 4'h0;
`endif
        end else begin
            r_shadow     <= w_shadow_next;
            r_shadow_err <= w_err_next;
            r_mask       <= w_frame ? 4'h0 : w_mask_next;
            r_frame_done <= w_frame;
`ifdef SS_ENC_DP_EN
            r_shadow_dp  <= w_dp_next;
`endif
            if (w_frame) begin
                r_value <= w_shadow_next;
                r_err   <= w_err_next;
                r_valid <= 1'b1;
`ifdef SS_ENC_DP_EN
                r_dp    <= w_dp_next;
`endif
            end
        end
    end

    assign value      = r_value;
    assign valid      = r_valid;
    assign digit_err  = r_err;
    assign frame_done = r_frame_done;
`ifdef SS_ENC_DP_EN
    assign dp         = r_dp;
`endif

endmodule
`default_nettype wire
